// File: rtl/ps2_kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_kbd_pkg
// Purpose : Shared register map, status bit positions and receiver states.
// Revision: 1.0 - initial release
// ============================================================================
package ps2_kbd_pkg;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STAT_IE        = 15;
  localparam int STAT_OVF       = 14;
  localparam int STAT_FERR      = 13;
  localparam int STAT_PERR      = 12;
  localparam int STAT_COUNT_LSB = 0;
  localparam int STAT_COUNT_W   = 9;

  localparam int DATA_VALID_BIT = 8;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/ps2_kbd_ctrl_rx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_rx_frame
// Purpose : PS/2 pin conditioning and 11-bit frame receiver with timeout.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_rx_frame
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       perr,
  output logic       ferr
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYC);

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [FW-1:0] fcnt [2];
  logic          filt_c_q;

  logic          fall;
  logic          sdat;

  rx_state_t     state;
  rx_state_t     state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          push_c;
  logic          perr_c;
  logic          ferr_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      filt    <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1 <= {ps2d, ps2c};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FILT_LAST) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FW'(1);
        end
      end
    end
  end

  assign fall = filt_c_q & ~filt[0];
  assign sdat = filt[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RX_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    push_c  = 1'b0;
    perr_c  = 1'b0;
    ferr_c  = 1'b0;
    if (state != RX_IDLE && !fall && tcnt == TO_LIMIT) begin
      state_d = RX_IDLE;
      ferr_c  = 1'b1;
    end else if (fall) begin
      case (state)
        RX_IDLE:   if (!sdat) state_d = RX_DATA;
        RX_DATA:   if (bit_cnt == 3'd7) state_d = RX_PARITY;
        RX_PARITY: state_d = RX_STOP;
        RX_STOP: begin
          state_d = RX_IDLE;
          // A bad stop bit masks any parity error in the same frame.
          if (!sdat) begin
            ferr_c = 1'b1;
          end else if (!(^{shreg, par_bit})) begin
            perr_c = 1'b1;
          end else begin
            push_c = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_c_q <= 1'b1;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tcnt     <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      filt_c_q <= filt[0];
      rx_valid <= push_c;
      perr     <= perr_c;
      ferr     <= ferr_c;
      if (push_c) rx_byte <= shreg;

      if (fall || state == RX_IDLE) begin
        tcnt <= '0;
      end else if (tcnt != TO_LIMIT) begin
        tcnt <= tcnt + TW'(1);
      end

      if (fall) begin
        case (state)
          RX_IDLE: bit_cnt <= '0;
          RX_DATA: begin
            shreg   <= {sdat, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          RX_PARITY: par_bit <= sdat;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ps2_kbd_ctrl
// Purpose : PS/2 keyboard bus slave: receiver, scancode FIFO, flags, IRQ.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic        STB,
  input  logic        WE,
  input  logic        ADDR,
  input  logic [31:0] DATA_I,
  output logic [31:0] DATA_O,
  output logic        ACK,
  input  logic        PS2C,
  input  logic        PS2D,
  output logic        INT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_perr;
  logic          rx_ferr;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          ie;
  logic          ovf;
  logic          ferr;
  logic          perr;

  logic          accept;
  logic          empty;
  logic          full;
  logic          pop;
  logic          do_write;
  logic          ovf_set;
  logic          wr_stat;
  logic [31:0]   status_word;
  logic [31:0]   rd_word;
  logic          unused_data_i;

  ps2_rx_frame #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk      (clk_cpu),
    .reset    (reset),
    .ps2c     (PS2C),
    .ps2d     (PS2D),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .perr     (rx_perr),
    .ferr     (rx_ferr)
  );

  assign accept   = STB & ~ACK;
  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign pop      = accept & ~WE & (ADDR == ADDR_DATA) & ~empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_write = rx_valid & (~full | pop);
  assign ovf_set  = rx_valid & full & ~pop;
  assign wr_stat  = accept & WE & (ADDR == ADDR_STATUS);

  assign unused_data_i = ^{DATA_I[31:16], DATA_I[11:0]};

  always_comb begin
    status_word = '0;
    status_word[STAT_IE]   = ie;
    status_word[STAT_OVF]  = ovf;
    status_word[STAT_FERR] = ferr;
    status_word[STAT_PERR] = perr;
    status_word[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(count);
  end

  always_comb begin
    rd_word = '0;
    if (ADDR == ADDR_STATUS) begin
      rd_word = status_word;
    end else if (!empty) begin
      rd_word[DATA_VALID_BIT] = 1'b1;
      rd_word[7:0]            = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (do_write) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ie     <= 1'b0;
      ovf    <= 1'b0;
      ferr   <= 1'b0;
      perr   <= 1'b0;
      ACK    <= 1'b0;
      DATA_O <= '0;
      INT    <= 1'b0;
    end else begin
      ACK    <= accept;
      DATA_O <= (accept && !WE) ? rd_word : '0;

      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      if (do_write && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !do_write) begin
        count <= count - CW'(1);
      end

      if (wr_stat) ie <= DATA_I[STAT_IE];
      ovf  <= (ovf  & ~(wr_stat & DATA_I[STAT_OVF]))  | ovf_set;
      ferr <= (ferr & ~(wr_stat & DATA_I[STAT_FERR])) | rx_ferr;
      perr <= (perr & ~(wr_stat & DATA_I[STAT_PERR])) | rx_perr;

      INT <= ie & ~empty;
    end
  end

endmodule
`default_nettype wire
